// File: rtl/switch_route_sequencer_pkg.sv
// Shared definitions for the route sequencer: idle control word, route-table
// entry layout and the sub-field map of the 19-bit switch control word.
package switch_route_sequencer_pkg;

  localparam int unsigned CTRL_W = 19;

  localparam int unsigned CTRL_IN_SEL_LSB     = 0;
  localparam int unsigned CTRL_IN_SEL_W       = 3;
  localparam int unsigned CTRL_OUT_SEL_LSB    = 3;
  localparam int unsigned CTRL_OUT_SEL_W      = 4;
  localparam int unsigned CTRL_SHIFT_CTRL_LSB = 7;
  localparam int unsigned CTRL_SHIFT_CTRL_W   = 3;
  localparam int unsigned CTRL_SHIFT_REG_LSB  = 10;
  localparam int unsigned CTRL_SHIFT_REG_W    = 9;

  localparam int unsigned ENTRY_CTRL_LSB  = 0;
  localparam int unsigned ENTRY_WS_BIT    = 19;
  localparam int unsigned ENTRY_BEATS_LSB = 20;
  localparam int unsigned ENTRY_FIXED_W   = 20;

  // Idle word: no input selected, output 0, shifter parked at its neutral setting.
  localparam logic [CTRL_IN_SEL_W-1:0]     IDLE_IN_SEL     = 3'd0;
  localparam logic [CTRL_OUT_SEL_W-1:0]    IDLE_OUT_SEL    = 4'd0;
  localparam logic [CTRL_SHIFT_CTRL_W-1:0] IDLE_SHIFT_CTRL = 3'd1;
  localparam logic [CTRL_SHIFT_REG_W-1:0]  IDLE_SHIFT_REG  = 9'h040;

  localparam logic [CTRL_W-1:0] IDLE_CTRL_DEFAULT =
      (CTRL_W'(IDLE_SHIFT_REG)  << CTRL_SHIFT_REG_LSB)  |
      (CTRL_W'(IDLE_SHIFT_CTRL) << CTRL_SHIFT_CTRL_LSB) |
      (CTRL_W'(IDLE_OUT_SEL)    << CTRL_OUT_SEL_LSB)    |
      (CTRL_W'(IDLE_IN_SEL)     << CTRL_IN_SEL_LSB);

endpackage

// File: rtl/switch_route_sequencer_route_table.sv
// Route table: register file of sequencer entries with a synchronous write port
// and a registered read port; contents clear to zero in reset.
module switch_route_sequencer_route_table
  import switch_route_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned ENTRY_W     = ENTRY_FIXED_W + 16,
  localparam int unsigned AW         = $clog2(NUM_ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [NUM_ENTRIES];
  logic [ENTRY_W-1:0] rdata_q;

  // Storage array with write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/switch_route_sequencer.sv
// Steps a crossbar switch through a programmed list of route entries, holding
// each control word for a fixed number of accepted beats, for one or more passes.
module switch_route_sequencer
  import switch_route_sequencer_pkg::*;
#(
  parameter int unsigned       NUM_ENTRIES = 8,
  parameter int unsigned       BEAT_W      = 16,
  parameter logic [CTRL_W-1:0] IDLE_CTRL   = IDLE_CTRL_DEFAULT,
  localparam int unsigned      AW          = $clog2(NUM_ENTRIES),
  localparam int unsigned      EW          = ENTRY_FIXED_W + BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [EW-1:0]     cfg_wdata,
  input  logic              start,
  input  logic [AW:0]       num_entries,
  input  logic [7:0]        repeat_cnt,
  input  logic              abort,
  input  logic              count_switch_tvalid,
  output logic [CTRL_W-1:0] ctrl,
  output logic              weight_switch,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     entry_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_NEXT = 2'd3
  } state_e;

  localparam logic [AW-1:0]     IDX_STEP  = AW'(1'b1);
  localparam logic [AW:0]       NUM_STEP  = (AW + 1)'(1'b1);
  localparam logic [BEAT_W-1:0] BEAT_STEP = BEAT_W'(1'b1);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ws_q, ws_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [AW:0]       num_q, num_d;
  logic [7:0]        pass_q, pass_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [BEAT_W-1:0] lim_q, lim_d;

  logic [EW-1:0]     rd_entry_s;
  logic [CTRL_W-1:0] rd_ctrl_s;
  logic              rd_ws_s;
  logic [BEAT_W-1:0] rd_beats_s;
  logic              start_ok_s;
  logic              more_entries_s;
  logic              more_passes_s;
  logic              last_beat_s;
  logic              table_we_s;

  // The table is addressed with the next entry index so its registered read
  // lands exactly in the LOAD cycle.
  switch_route_sequencer_route_table #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ENTRY_W     (EW)
  ) u_route_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (table_we_s),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .raddr_i (idx_d),
    .rdata_o (rd_entry_s)
  );

  assign rd_ctrl_s      = rd_entry_s[ENTRY_CTRL_LSB +: CTRL_W];
  assign rd_ws_s        = rd_entry_s[ENTRY_WS_BIT];
  assign rd_beats_s     = rd_entry_s[ENTRY_BEATS_LSB +: BEAT_W];
  assign table_we_s     = cfg_we && (state_q == ST_IDLE);
  assign start_ok_s     = start && !abort;
  assign more_entries_s = (({1'b0, idx_q} + NUM_STEP) < num_q);
  assign more_passes_s  = (pass_q != 8'd0);
  assign last_beat_s    = count_switch_tvalid && (cnt_q == (lim_q - BEAT_STEP));

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= IDLE_CTRL;
      ws_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      num_q   <= '0;
      pass_q  <= 8'd0;
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      ws_q    <= ws_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  // Next-state logic; abort takes priority over every other event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s && (num_entries != '0)) state_d = ST_LOAD;
        else                                   state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort)                    state_d = ST_IDLE;
        else if (rd_beats_s == '0)    state_d = ST_NEXT;
        else                          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort)            state_d = ST_IDLE;
        else if (last_beat_s) state_d = ST_NEXT;
        else                  state_d = ST_RUN;
      end
      ST_NEXT: begin
        if (abort)                                  state_d = ST_IDLE;
        else if (more_entries_s || more_passes_s)   state_d = ST_LOAD;
        else                                        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and counter next values. The control word is only live while the
  // next state is RUN, so it drops on the edge that takes the final beat.
  always_comb begin
    ctrl_d = IDLE_CTRL;
    ws_d   = 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = 1'b0;
    idx_d  = idx_q;
    num_d  = num_q;
    pass_d = pass_q;
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          idx_d  = '0;
          num_d  = num_entries;
          pass_d = repeat_cnt;
          cnt_d  = '0;
          done_d = (num_entries == '0);
        end else begin
          done_d = 1'b0;
        end
      end
      ST_LOAD: begin
        cnt_d = '0;
        lim_d = rd_beats_s;
        if (state_d == ST_RUN) begin
          ctrl_d = rd_ctrl_s;
          ws_d   = rd_ws_s;
        end else begin
          ctrl_d = IDLE_CTRL;
          ws_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (state_d == ST_RUN) begin
          ctrl_d = ctrl_q;
          ws_d   = ws_q;
        end else begin
          ctrl_d = IDLE_CTRL;
          ws_d   = 1'b0;
        end
        if (count_switch_tvalid) cnt_d = cnt_q + BEAT_STEP;
        else                     cnt_d = cnt_q;
      end
      ST_NEXT: begin
        if (abort) begin
          done_d = 1'b0;
        end else if (more_entries_s) begin
          idx_d = idx_q + IDX_STEP;
        end else if (more_passes_s) begin
          idx_d  = '0;
          pass_d = pass_q - 8'd1;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        ctrl_d = IDLE_CTRL;
        ws_d   = 1'b0;
      end
    endcase
  end

  assign ctrl          = ctrl_q;
  assign weight_switch = ws_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign entry_idx     = idx_q;

endmodule

// File: tb/tb_switch_route_sequencer.sv
// Self-checking bench: a cycle vector table for the single-entry run, hand
// sequences for abort/freeze/reset, and random runs against a visit-level model.
module tb_switch_route_sequencer;

  localparam int NE = 8;
  localparam logic [18:0] IDLE = 19'h10080;

  logic        clk = 1'b0;
  logic        rst_n, cfg_we, start, abort, tvalid;
  logic [2:0]  cfg_addr;
  logic [35:0] cfg_wdata;
  logic [3:0]  num_entries;
  logic [7:0]  repeat_cnt;
  logic [18:0] ctrl;
  logic        weight_switch, busy, done;
  logic [2:0]  entry_idx;

  int total = 0;
  int bad   = 0;

  logic [18:0] m_ctrl  [NE];
  logic        m_ws    [NE];
  int          m_beats [NE];

  typedef struct packed {
    logic        start;
    logic [3:0]  num;
    logic        abort;
    logic        tv;
    logic [18:0] e_ctrl;
    logic        e_ws;
    logic        e_busy;
    logic        e_done;
  } vec_t;
  vec_t vecs [10];

  always #5 clk = ~clk;

  switch_route_sequencer #(.NUM_ENTRIES(8), .BEAT_W(16), .IDLE_CTRL(19'h10080)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .num_entries(num_entries), .repeat_cnt(repeat_cnt), .abort(abort),
    .count_switch_tvalid(tvalid), .ctrl(ctrl), .weight_switch(weight_switch),
    .busy(busy), .done(done), .entry_idx(entry_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input int act);
    total++;
    bad++;
    $display("FAIL %s: got %0d want none", name, act);
  endtask

  task automatic cfg_write(input int a, input logic [18:0] c, input logic w, input int b);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_wdata = {16'(b), w, c};
    tick();
    cfg_we = 1'b0;
    m_ctrl[a] = c;
    m_ws[a] = w;
    m_beats[a] = b;
  endtask

  function automatic logic [18:0] rand_ctrl();
    logic [18:0] c;
    c = 19'($urandom);
    if (c == IDLE) c = c ^ 19'h00001;
    return c;
  endfunction

  // Runs one pass set from idle; the model is the ordered list of entry visits.
  task automatic run_check(input int num, input int rep, input int pct, input string tag);
    int exp_q[$];
    int idx_cyc [NE];
    int busy_cyc, run_cyc, seg_beats, cur_k, beats_sum, exp_sum;
    bit in_seg, last_tv, fin;
    logic tv;
    busy_cyc = 0; run_cyc = 0; seg_beats = 0; cur_k = 0; beats_sum = 0; exp_sum = 0;
    in_seg = 1'b0; last_tv = 1'b0; fin = 1'b0;
    for (int i = 0; i < NE; i++) idx_cyc[i] = 0;
    for (int p = 0; p <= rep; p++) begin
      for (int k = 0; k < num; k++) begin
        exp_sum += m_beats[k];
        if (m_beats[k] != 0) exp_q.push_back(k);
      end
    end
    start = 1'b1; num_entries = 4'(num); repeat_cnt = 8'(rep); tvalid = 1'b0;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (done) begin
        chk({tag, " busy at done"}, busy, 1'b0);
        fin = 1'b1;
      end else if (!busy) begin
        note_fail({tag, " stopped without done"}, cyc);
        fin = 1'b1;
      end else begin
        busy_cyc++;
        idx_cyc[entry_idx]++;
        if (ctrl !== IDLE) begin
          run_cyc++;
          if (!in_seg) begin
            in_seg = 1'b1;
            seg_beats = 0;
            if (exp_q.size() == 0) begin
              note_fail({tag, " unexpected entry"}, int'(entry_idx));
              cur_k = int'(entry_idx);
            end else begin
              cur_k = exp_q.pop_front();
              chk({tag, " entry idx"}, entry_idx, cur_k);
              chk({tag, " entry ctrl"}, ctrl, m_ctrl[cur_k]);
              chk({tag, " entry ws"}, weight_switch, m_ws[cur_k]);
            end
          end
          tv = ($urandom_range(99) < pct);
          if (tv) seg_beats++;
          last_tv = tv;
        end else begin
          if (in_seg) begin
            in_seg = 1'b0;
            chk({tag, " beats on entry"}, seg_beats, m_beats[cur_k]);
            chk({tag, " entry ends on beat"}, last_tv, 1'b1);
            beats_sum += seg_beats;
          end
          tv = 1'($urandom_range(1));
        end
        tvalid = tv;
        tick();
      end
    end
    tvalid = 1'b0;
    if (!fin) note_fail({tag, " timeout"}, 4000);
    chk({tag, " visits left"}, exp_q.size(), 0);
    chk({tag, " beat total"}, beats_sum, exp_sum);
    chk({tag, " busy cycles"}, busy_cyc, 2 * num * (rep + 1) + run_cyc);
    for (int k = 0; k < num; k++) begin
      if (m_beats[k] == 0) chk({tag, " zero-beat entry cycles"}, idx_cyc[k], 2 * (rep + 1));
    end
    tick();
    chk({tag, " done single pulse"}, done, 1'b0);
  endtask

  initial begin
    int n, r;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 36'd0; start = 1'b0;
    num_entries = 4'd0; repeat_cnt = 8'd0; abort = 1'b0; tvalid = 1'b0;
    for (int i = 0; i < NE; i++) begin m_ctrl[i] = 19'd0; m_ws[i] = 1'b0; m_beats[i] = 0; end
    tick(); tick();
    chk("reset ctrl", ctrl, IDLE);
    chk("reset ws", weight_switch, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset idx", entry_idx, 3'd0);
    rst_n = 1'b1;
    tick();

    // Single entry, 4 beats, tvalid every cycle, then a zero-length start.
    cfg_write(0, 19'h00009, 1'b1, 4);
    vecs[0] = '{1'b1, 4'd1, 1'b0, 1'b1, IDLE,      1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 4'd1, 1'b0, 1'b1, 19'h00009, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'd1, 1'b0, 1'b1, 19'h00009, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'd1, 1'b0, 1'b1, 19'h00009, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 4'd1, 1'b0, 1'b1, 19'h00009, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'd1, 1'b0, 1'b1, IDLE,      1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 4'd1, 1'b0, 1'b1, IDLE,      1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 4'd1, 1'b0, 1'b0, IDLE,      1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 4'd0, 1'b0, 1'b0, IDLE,      1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 4'd0, 1'b0, 1'b0, IDLE,      1'b0, 1'b0, 1'b0};
    repeat_cnt = 8'd0;
    for (int i = 0; i < 10; i++) begin
      start = vecs[i].start; num_entries = vecs[i].num; abort = vecs[i].abort; tvalid = vecs[i].tv;
      tick();
      chk($sformatf("vec%0d ctrl", i), ctrl, vecs[i].e_ctrl);
      chk($sformatf("vec%0d ws", i), weight_switch, vecs[i].e_ws);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d done", i), done, vecs[i].e_done);
    end
    start = 1'b0; tvalid = 1'b0;

    // Two entries, two passes, 50% tvalid: 10 beats in order 0,1,0,1.
    cfg_write(0, 19'h00A11, 1'b0, 3);
    cfg_write(1, 19'h04822, 1'b1, 2);
    run_check(2, 1, 50, "two-entry");

    // Zero-beat middle entry is skipped in two cycles.
    cfg_write(0, rand_ctrl(), 1'b0, 2);
    cfg_write(1, rand_ctrl(), 1'b1, 0);
    cfg_write(2, rand_ctrl(), 1'b0, 1);
    run_check(3, 0, 70, "skip");

    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(4, 1));
      r = int'($urandom_range(2, 0));
      for (int k = 0; k < n; k++) cfg_write(k, rand_ctrl(), 1'($urandom_range(1)), int'($urandom_range(4, 0)));
      run_check(n, r, int'($urandom_range(100, 30)), $sformatf("rand%0d", t));
    end

    // Abort after 2 of 5 beats, with a simultaneous start and beat.
    cfg_write(0, 19'h00123, 1'b1, 5);
    start = 1'b1; num_entries = 4'd1; repeat_cnt = 8'd0;
    tick();
    start = 1'b0;
    tick();
    tvalid = 1'b1;
    tick(); tick();
    chk("abort pre ctrl", ctrl, 19'h00123);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; tvalid = 1'b0;
    chk("abort ctrl", ctrl, IDLE);
    chk("abort ws", weight_switch, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    tick();
    chk("abort no late done", done, 1'b0);

    // Start and table write while busy are ignored.
    cfg_write(0, 19'h00321, 1'b0, 3);
    start = 1'b1; num_entries = 4'd1; repeat_cnt = 8'd0;
    tick();
    start = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = {16'd1, 1'b1, 19'h07777};
    start = 1'b1; num_entries = 4'd2; tvalid = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    chk("busy-write busy", busy, 1'b1);
    chk("busy-write ctrl", ctrl, 19'h00321);
    tick(); tick();
    tvalid = 1'b0;
    chk("busy-write next ctrl", ctrl, IDLE);
    chk("busy-write next busy", busy, 1'b1);
    tick();
    chk("busy-write done", done, 1'b1);
    tick();
    chk("busy-write no restart", busy, 1'b0);
    run_check(1, 0, 100, "frozen");

    // Reset in the middle of entry 1, then a run over the cleared table.
    cfg_write(1, 19'h05555, 1'b1, 4);
    start = 1'b1; num_entries = 4'd2; repeat_cnt = 8'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && !(entry_idx == 3'd1 && ctrl != IDLE); i++) begin
      tvalid = 1'b1;
      tick();
    end
    tvalid = 1'b0;
    chk("reached entry1", entry_idx, 3'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrun rst ctrl", ctrl, IDLE);
    chk("midrun rst ws", weight_switch, 1'b0);
    chk("midrun rst busy", busy, 1'b0);
    chk("midrun rst done", done, 1'b0);
    chk("midrun rst idx", entry_idx, 3'd0);
    tick();
    chk("midrun rst no done", done, 1'b0);
    for (int i = 0; i < NE; i++) begin m_ctrl[i] = 19'd0; m_ws[i] = 1'b0; m_beats[i] = 0; end
    run_check(1, 0, 50, "cleared");
    start = 1'b1; num_entries = 4'd0;
    tick();
    start = 1'b0;
    chk("empty start done", done, 1'b1);
    chk("empty start busy", busy, 1'b0);
    tick();
    chk("empty start done once", done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
